fact_seq: RTL and testbench
===========================

# fact_seq

Job sequencer that sits directly upstream of the `fact` factorial core. It buffers incoming n requests in a small FIFO and issues them one at a time over the core's go/Done/Error handshake. It captures each result, with its n and error flag, into a response FIFO for the downstream consumer, and adds a watchdog so that a hung core cannot stall the queue.

## Interface
- DEPTH, 4, entries in each of the request and response FIFOs (power of two, ≥2)
- TIMEOUT, 255, max cycles in RUN or CLEAR before the watchdog fires (≥2)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_n  in  4  factorial operand
- req_ready  out  1  request FIFO not full
- rsp_valid  out  1  response FIFO not empty
- rsp_ready  in  1  consumer accepts head response
- rsp_n  out  4  operand of head response
- rsp_result  out  32  result of head response
- rsp_error  out  1  core Error or watchdog timeout for head response
- core_go  out  1  to fact `go`
- core_in  out  4  to fact `in`
- core_done  in  1  from fact `Done`
- core_error  in  1  from fact `Error`
- core_result  in  32  from fact `result`
- busy  out  1  state ≠ IDLE or request FIFO non-empty

## Operation
- Request FIFO: push on req_valid & req_ready. req_ready = !full, evaluated from the registered count. Push and pop in the same cycle are legal when non-empty.
- Response FIFO: each entry is {n, result, error}. Pop on rsp_valid & rsp_ready. rsp_* show the head entry combinationally from the registered FIFO. Push and pop in the same cycle are legal.
- FSM states: IDLE, RUN, CLEAR.
  - IDLE → RUN when the request FIFO is non-empty and the response FIFO is not full. At that edge core_in is loaded with the head n and core_go is set to 1. The timer clears.
  - RUN: core_go stays 1 and core_in stays stable. The timer increments every cycle.
    - If core_done | core_error is sampled high: push {core_in, core_result, core_error} and pop the request FIFO. Then set core_go = 0, clear the timer and go to CLEAR.
    - If instead timer == TIMEOUT−1: push {core_in, 32'h0, 1} and pop the request. Then set core_go = 0, clear the timer and go to CLEAR.
  - CLEAR: core_go = 0. Go to IDLE once core_done == 0 and core_error == 0 are sampled, or once timer == TIMEOUT−1.
- Only one job is in flight at a time. A response slot is guaranteed because the pop-only consumer can only free space between the IDLE check and the push.
- Response order always equals request order.
- Operand values are passed through unchanged. Range checking (13! overflows 32 bits) is the core's job via Error.

## Timing
- Reset (async assert, released synchronously to clk): state = IDLE, both FIFOs empty, timer = 0.
  - Outputs in reset: core_go = 0, core_in = 0, req_ready = 1, rsp_valid = 0, rsp_n = 0, rsp_result = 0, rsp_error = 0, busy = 0.
- Reset asserted mid-RUN or mid-CLEAR drops core_go immediately. All queued requests and responses are discarded.
- Latency:
  - A request accepted at edge k into an empty, idle block gives core_go = 1 after edge k+1.
  - Done sampled at edge m gives rsp_valid = 1 after edge m.
  - The next issue happens no earlier than edge m+2.
- core_done and core_error are ignored in IDLE.
- core_done | core_error sampled high on the same edge that the timer hits TIMEOUT−1: the core response wins, with the core's result and error.
- Request FIFO full: req_ready = 0 even if a pop occurs in the same cycle. Pushes while not ready are dropped by protocol, and the requester must hold req_valid.
- Response FIFO full: the FSM holds in IDLE and the request FIFO keeps filling up to DEPTH.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. The counts are log2(DEPTH)+1 bits.

## Test plan
- Single job: n = 3 against a real `fact`, rsp_ready = 1 → one response {3, 6, 0}. core_go falls on the cycle after Done is sampled.
- Burst with backpressure: push n = 5, 6, 7, 8 with rsp_ready = 0.
  - Expect 4 responses queued and req_ready still 1 (the request FIFO has drained).
  - Push 4 more (n = 9, 10, 11, 12); they queue up and req_ready goes to 0.
  - Release rsp_ready → results 120, 720, 5040, 40320, 362880, 3628800, 39916800, 479001600, in order and all with error = 0.
- Error path: n = 13, core Error asserted → response {13, core result, 1}; the next request n = 4 still returns 24.
- Watchdog: stub core that never asserts Done, TIMEOUT = 16, n = 2 → response {2, 0, 1} exactly 16 cycles after core_go rises. The stub is then kept stuck and the FSM returns to IDLE after CLEAR times out.
- Simultaneous events: Done arrives on the timeout edge → the core result is taken. A rsp push and pop in the same cycle on a one-entry FIFO leaves the count unchanged.
- Reset mid-RUN (n = 10, reset 3 cycles after core_go rises) → core_go = 0 and rsp_valid = 0 immediately. After release, n = 3 returns 6.

Source files
------------

// File: rtl/fact_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fact_seq
//  Purpose  : Job sequencer in front of the fact factorial core. Requests
//             (n) are buffered in a FIFO and issued one at a time over the
//             core's go/Done/Error handshake. Each outcome {n, result, error}
//             is stored in a response FIFO. A watchdog bounds the time spent
//             waiting on the core, both for the answer (RUN) and for the
//             handshake release (CLEAR).
//  Ports    : clk, rst          - clock, asynchronous active-high reset
//             req_valid/req_n   - request in, req_ready = request FIFO not full
//             rsp_valid/rsp_*   - head of response FIFO, popped by rsp_ready
//             core_go/core_in   - drive fact go / in
//             core_done/error   - fact Done / Error, core_result = fact result
//             busy              - job in flight or requests pending
//  Revision : 1.0 - initial release
// ============================================================================
module fact_seq #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [3:0]  req_n,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [3:0]  rsp_n,
    output logic [31:0] rsp_result,
    output logic        rsp_error,
    output logic        core_go,
    output logic [3:0]  core_in,
    input  logic        core_done,
    input  logic        core_error,
    input  logic [31:0] core_result,
    output logic        busy
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;
    localparam int c_TMR_W  = $clog2(TIMEOUT + 1);
    localparam int c_RSP_W  = 4 + 32 + 1;
    localparam logic [c_TMR_W-1:0] c_TMO_LAST = c_TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_TMR_W-1:0]   r_timer;
    logic [3:0]           r_core_in;

    // ---------------- request FIFO ----------------
    logic [3:0]           r_req_mem [DEPTH];
    logic [c_ADDR_W-1:0]  r_req_wr;
    logic [c_ADDR_W-1:0]  r_req_rd;
    logic [c_CNT_W-1:0]   r_req_cnt;
    logic                 w_req_full;
    logic                 w_req_empty;
    logic                 w_req_push;
    logic                 w_req_pop;

    // ---------------- response FIFO ----------------
    logic [c_RSP_W-1:0]   r_rsp_mem [DEPTH];
    logic [c_ADDR_W-1:0]  r_rsp_wr;
    logic [c_ADDR_W-1:0]  r_rsp_rd;
    logic [c_CNT_W-1:0]   r_rsp_cnt;
    logic                 w_rsp_full;
    logic                 w_rsp_empty;
    logic                 w_rsp_push;
    logic                 w_rsp_pop;
    logic [c_RSP_W-1:0]   w_rsp_wdata;
    logic [c_RSP_W-1:0]   w_rsp_head;

    // FSM strobes
    logic                 w_issue;
    logic                 w_complete;
    logic                 w_timeout;

    assign w_req_full  = (r_req_cnt == c_CNT_W'(DEPTH));
    assign w_req_empty = (r_req_cnt == '0);
    assign w_req_push  = req_valid & ~w_req_full;
    assign req_ready   = ~w_req_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_wr  <= '0;
            r_req_rd  <= '0;
            r_req_cnt <= '0;
        end else begin
            if (w_req_push) r_req_wr <= r_req_wr + 1'b1;
            if (w_req_pop)  r_req_rd <= r_req_rd + 1'b1;
            case ({w_req_push, w_req_pop})
                2'b10:   r_req_cnt <= r_req_cnt + 1'b1;
                2'b01:   r_req_cnt <= r_req_cnt - 1'b1;
                default: r_req_cnt <= r_req_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_req_push) r_req_mem[r_req_wr] <= req_n;
    end

    assign w_rsp_full  = (r_rsp_cnt == c_CNT_W'(DEPTH));
    assign w_rsp_empty = (r_rsp_cnt == '0);
    assign w_rsp_pop   = rsp_ready & ~w_rsp_empty;
    assign w_rsp_head  = r_rsp_mem[r_rsp_rd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_wr  <= '0;
            r_rsp_rd  <= '0;
            r_rsp_cnt <= '0;
        end else begin
            if (w_rsp_push) r_rsp_wr <= r_rsp_wr + 1'b1;
            if (w_rsp_pop)  r_rsp_rd <= r_rsp_rd + 1'b1;
            case ({w_rsp_push, w_rsp_pop})
                2'b10:   r_rsp_cnt <= r_rsp_cnt + 1'b1;
                2'b01:   r_rsp_cnt <= r_rsp_cnt - 1'b1;
                default: r_rsp_cnt <= r_rsp_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_rsp_push) r_rsp_mem[r_rsp_wr] <= w_rsp_wdata;
    end

    // Response storage is not reset, so the head is masked while empty.
    assign rsp_valid  = ~w_rsp_empty;
    assign rsp_n      = rsp_valid ? w_rsp_head[36:33] : 4'd0;
    assign rsp_result = rsp_valid ? w_rsp_head[32:1]  : 32'd0;
    assign rsp_error  = rsp_valid ? w_rsp_head[0]     : 1'b0;

    // ---------------- sequencing FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // The consumer only pops, so a free slot seen here is still
                // free when this job's response is pushed.
                if (!w_req_empty && !w_rsp_full) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // The core answer takes priority over a watchdog expiry.
                if (core_done || core_error) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_CLEAR;
                end else if (r_timer == c_TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if ((!core_done && !core_error) || (r_timer == c_TMO_LAST))
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_req_pop   = w_complete | w_timeout;
    assign w_rsp_push  = w_complete | w_timeout;
    assign w_rsp_wdata = w_complete ? {r_core_in, core_result, core_error}
                                    : {r_core_in, 32'h0, 1'b1};

    // Timer restarts on every state change and only runs outside IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         r_timer <= '0;
        else if (w_state_nxt != r_state) r_timer <= '0;
        else if (r_state != ST_IDLE)     r_timer <= r_timer + c_TMR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_core_in <= 4'd0;
        else if (w_issue) r_core_in <= r_req_mem[r_req_rd];
    end

    // go is exactly "in RUN", so an async reset removes it at once.
    assign core_go = (r_state == ST_RUN);
    assign core_in = r_core_in;
    assign busy    = (r_state != ST_IDLE) || !w_req_empty;

endmodule
`default_nettype wire

// File: tb/tb_fact_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fact_seq
//  Purpose  : Directed bench for fact_seq with a stub factorial core whose
//             behaviour (normal, stuck low, stuck high, late answer) is
//             selected per test. Expected responses are queued on request
//             acceptance and compared by an independent monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fact_seq;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [3:0]  req_n;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_n;
    logic [31:0] rsp_result;
    logic        rsp_error;
    logic        core_go;
    logic [3:0]  core_in;
    logic        core_done;
    logic        core_error;
    logic [31:0] core_result;
    logic        busy;

    always #5 clk = ~clk;

    fact_seq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_n      (req_n),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_n      (rsp_n),
        .rsp_result (rsp_result),
        .rsp_error  (rsp_error),
        .core_go    (core_go),
        .core_in    (core_in),
        .core_done  (core_done),
        .core_error (core_error),
        .core_result(core_result),
        .busy       (busy)
    );

    // ---------------- stub core ----------------
    // mode 0: answer after 2+n[1:0] cycles, Error for n>12
    // mode 1: never answers
    // mode 2: Done stuck high, result 0xBAD
    // mode 3: answer exactly on the watchdog edge (15 cycles)
    int         mode;
    logic [7:0] m_cnt;
    logic [7:0] m_lat;
    logic       m_fire;

    function automatic logic [31:0] fact_f(input logic [3:0] n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 2; i <= int'(n); i++) r = r * i;
        return r;
    endfunction

    always @(posedge clk) begin
        if (!core_go)            m_cnt <= 8'd0;
        else if (m_cnt != 8'hff) m_cnt <= m_cnt + 8'd1;
    end

    assign m_lat       = (mode == 3) ? 8'd15 : (8'd2 + {6'd0, core_in[1:0]});
    assign m_fire      = core_go && (m_cnt >= m_lat) && (mode == 0 || mode == 3);
    assign core_done   = (mode == 2) || (m_fire && core_in <= 4'd12);
    assign core_error  = m_fire && core_in > 4'd12;
    assign core_result = (mode == 2) ? 32'h0000_0BAD :
                         (core_in > 4'd12) ? 32'hDEAD_BEEF : fact_f(core_in);

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [3:0]  n;
        logic [31:0] res;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t e_mon;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got n=%0d result=%0h err=%0b expected none",
                         rsp_n, rsp_result, rsp_error);
            end else begin
                e_mon = exp_q.pop_front();
                chk("rsp_n", 64'(rsp_n), 64'(e_mon.n));
                chk("rsp_result", 64'(rsp_result), 64'(e_mon.res));
                chk("rsp_error", 64'(rsp_error), 64'(e_mon.err));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic push(input logic [3:0] n, input logic [31:0] r, input logic e);
        int   b;
        rsp_t t;
        b = 0;
        req_valid = 1'b1;
        req_n     = n;
        while (!req_ready && b < 300) begin
            step();
            b++;
        end
        if (!req_ready) begin
            chk("push_ready_timeout", 64'(req_ready), 64'd1);
        end else begin
            t.n = n; t.res = r; t.err = e;
            exp_q.push_back(t);
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_go();
        int b;
        b = 0;
        while (!core_go && b < 100) begin
            step();
            b++;
        end
        chk("wait_go", 64'(core_go), 64'd1);
    endtask

    task automatic wait_not_busy();
        int b;
        b = 0;
        while (busy && b < 500) begin
            step();
            b++;
        end
        chk("wait_not_busy", 64'(busy), 64'd0);
    endtask

    task automatic wait_quiet();
        int b;
        b = 0;
        while ((busy || rsp_valid || exp_q.size() != 0) && b < 1000) begin
            step();
            b++;
        end
        chk("quiet", {61'd0, busy, rsp_valid, exp_q.size() != 0}, 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int b;
        rst = 1'b1; req_valid = 1'b0; req_n = 4'd0; rsp_ready = 1'b1; mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_core_go",   64'(core_go),    64'd0);
        chk("rst_core_in",   64'(core_in),    64'd0);
        chk("rst_req_ready", 64'(req_ready),  64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid),  64'd0);
        chk("rst_rsp_n",     64'(rsp_n),      64'd0);
        chk("rst_rsp_res",   64'(rsp_result), 64'd0);
        chk("rst_rsp_err",   64'(rsp_error),  64'd0);
        chk("rst_busy",      64'(busy),       64'd0);
        step();
        rst = 1'b0;
        step();

        // Single job: go one edge after accept, drops right after Done.
        push(4'd3, 32'd6, 1'b0);
        chk("go_at_accept", 64'(core_go), 64'd0);
        step();
        chk("go_after_accept", 64'(core_go), 64'd1);
        chk("core_in_3", 64'(core_in), 64'd3);
        b = 0;
        while (!core_done && b < 50) begin step(); b++; end
        chk("go_before_done", 64'(core_go), 64'd1);
        step();
        chk("go_after_done", 64'(core_go), 64'd0);
        chk("rsp_valid_after_done", 64'(rsp_valid), 64'd1);
        wait_quiet();

        // Burst with backpressure.
        rsp_ready = 1'b0;
        push(4'd5, 32'd120, 1'b0);
        push(4'd6, 32'd720, 1'b0);
        push(4'd7, 32'd5040, 1'b0);
        push(4'd8, 32'd40320, 1'b0);
        wait_not_busy();
        chk("burst_req_ready", 64'(req_ready), 64'd1);
        chk("burst_rsp_valid", 64'(rsp_valid), 64'd1);
        push(4'd9,  32'd362880, 1'b0);
        push(4'd10, 32'd3628800, 1'b0);
        push(4'd11, 32'd39916800, 1'b0);
        push(4'd12, 32'd479001600, 1'b0);
        chk("burst_req_full", 64'(req_ready), 64'd0);
        chk("burst_busy", 64'(busy), 64'd1);
        rsp_ready = 1'b1;
        wait_quiet();

        // Error path, then a normal job.
        push(4'd13, 32'hDEAD_BEEF, 1'b1);
        push(4'd4, 32'd24, 1'b0);
        wait_quiet();

        // Watchdog in RUN: response exactly TIMEOUT cycles after go.
        mode = 1;
        push(4'd2, 32'd0, 1'b1);
        wait_go();
        repeat (15) step();
        chk("wd_rsp_early", 64'(rsp_valid), 64'd0);
        step();
        chk("wd_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("wd_go_low", 64'(core_go), 64'd0);
        wait_quiet();

        // Done stuck high: CLEAR must time out back to IDLE.
        mode = 2;
        push(4'd7, 32'h0000_0BAD, 1'b0);
        wait_go();
        step();
        chk("clr_rsp_valid", 64'(rsp_valid), 64'd1);
        repeat (15) step();
        chk("clr_busy_hold", 64'(busy), 64'd1);
        step();
        chk("clr_busy_drop", 64'(busy), 64'd0);
        mode = 0;
        wait_quiet();

        // Done on the watchdog edge: core answer wins.
        mode = 3;
        push(4'd5, 32'd120, 1'b0);
        wait_go();
        repeat (15) step();
        chk("sim_rsp_early", 64'(rsp_valid), 64'd0);
        step();
        chk("sim_rsp_valid", 64'(rsp_valid), 64'd1);
        mode = 0;
        wait_quiet();

        // Response push and pop on the same edge with one entry queued.
        rsp_ready = 1'b0;
        push(4'd6, 32'd720, 1'b0);
        wait_not_busy();
        push(4'd3, 32'd6, 1'b0);
        b = 0;
        while (!core_done && b < 50) begin step(); b++; end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("pp_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("pp_rsp_n", 64'(rsp_n), 64'd3);
        chk("pp_rsp_result", 64'(rsp_result), 64'd6);
        rsp_ready = 1'b1;
        step();
        chk("pp_rsp_empty", 64'(rsp_valid), 64'd0);
        wait_quiet();

        // Reset in the middle of RUN.
        push(4'd10, 32'd3628800, 1'b0);
        wait_go();
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("mrst_go", 64'(core_go), 64'd0);
        chk("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        step();
        rst = 1'b0;
        step();
        push(4'd3, 32'd6, 1'b0);
        wait_quiet();

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
